instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 12, instruction-memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  downstream cannot accept; hold the presented instruction.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken; refetch from redirect_pc.
REQ-008 SHALL have port redirect_pc  input  ADDRESS_WIDTH  redirect target word address.
REQ-009 SHALL have port rom_addr  output  ADDRESS_WIDTH  address to instruction ROM.
REQ-010 SHALL have port rom_wEn  output  1  ROM write enable; constant 0.
REQ-011 SHALL have port rom_data  input  DATA_WIDTH  ROM read data, valid one cycle after rom_addr is sampled.
REQ-012 SHALL have port instr  output  DATA_WIDTH  instruction presented downstream.
REQ-013 SHALL have port instr_pc  output  ADDRESS_WIDTH  address of instr.
REQ-014 SHALL have port instr_valid  output  1  instr/instr_pc are meaningful this cycle.
REQ-015 SHALL have port fetch_count  output  32  number of instructions accepted downstream since reset.

Function
REQ-016 SHALL hold registers pc, resp_pc, resp_valid, hold_valid, hold_instr, fetch_count, and state (BOOT, RUN, STALL).
REQ-017 SHALL drive rom_addr = pc combinationally from the pc register.
REQ-018 SHALL drive instr = hold_instr when hold_valid=1, else rom_data; instr_pc = resp_pc; instr_valid = resp_valid.
REQ-019 SHALL give redirect_valid priority over stall in every state.
REQ-020 On redirect: pc <= redirect_pc, resp_valid <= 0, hold_valid <= 0, state <= BOOT; one bubble cycle, target appears valid two edges after redirect sampled.
REQ-021 BOOT, no redirect: resp_pc <= pc, resp_valid <= 1, pc <= pc+1, state <= RUN; stall is ignored in BOOT since nothing is presented.
REQ-022 RUN, stall=0: resp_pc <= pc, resp_valid <= 1, pc <= pc+1, hold_valid <= 0, fetch_count += 1.
REQ-023 RUN, stall=1: pc, resp_pc, resp_valid held; hold_instr <= rom_data, hold_valid <= 1; state <= STALL.
REQ-024 STALL, stall=1: all registers held; instr stays equal to the captured hold_instr.
REQ-025 STALL, stall=0: behaves as REQ-022 (hold_valid <= 0, state <= RUN); next cycle rom_data = ROM[pc] held during stall, so no instruction is lost or duplicated.
REQ-026 pc+1 SHALL wrap modulo 2^ADDRESS_WIDTH (4095 -> 0) without any flag.
REQ-027 fetch_count SHALL increment only when instr_valid=1, stall=0, redirect_valid=0; wraps at 2^32.
REQ-028 Redirect arriving while in STALL SHALL discard the held instruction without counting it.

Reset
REQ-029 While reset=1 (asynchronously): pc = RESET_PC, resp_pc = 0, resp_valid = 0, hold_valid = 0, hold_instr = 0, fetch_count = 0, state = BOOT.
REQ-030 Outputs after reset: rom_addr = RESET_PC, instr_valid = 0, instr_pc = 0, fetch_count = 0, rom_wEn = 0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL override all other activity immediately, with no pending instruction surviving.

Verification
REQ-032 Reset release, ROM[n]=n+0x100, no stall -> edge1 instr_valid=1 instr=0x100 pc 0; edge2 0x101 pc 1; fetch_count counts 1,2,...
REQ-033 Stall held 3 cycles while instr_pc=5 presented -> instr=ROM[5], instr_pc=5 on all 3 cycles; after release next is pc 6; fetch_count increments once for pc 5.
REQ-034 redirect_valid=1, redirect_pc=0x200 while running -> next cycle instr_valid=0; following cycle instr_pc=0x200, instr=ROM[0x200].
REQ-035 Redirect and stall both asserted in STALL -> redirect wins; held instruction dropped, fetch_count unchanged, target fetched as in REQ-034.
REQ-036 RESET_PC=4094, run 4 cycles -> instr_pc sequence 4094, 4095, 0, 1.
REQ-037 reset pulsed asynchronously between edges during STALL -> instr_valid=0, rom_addr=RESET_PC, fetch_count=0 before the next edge.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a synchronous-read ROM and presents one instruction per cycle
// downstream, with stall hold, redirect, and an accepted-instruction counter.
module instr_fetch #(
  parameter int unsigned                ADDRESS_WIDTH = 12,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  output logic                     rom_wEn,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_valid,
  output logic [31:0]              fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] resp_pc;
  logic                     resp_valid;
  logic                     hold_valid;
  logic [DATA_WIDTH-1:0]    hold_instr;
  logic [31:0]              count;

  logic advance;
  logic capture;
  logic count_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = BOOT;
    end else begin
      unique case (state)
        BOOT:    state_next = RUN;
        RUN:     state_next = stall ? STALL : RUN;
        STALL:   state_next = stall ? STALL : RUN;
        default: state_next = BOOT;
      endcase
    end
  end

  // pc is held during a stall, so the ROM keeps returning ROM[pc] and the
  // presented instruction must be captured on the first stalled edge.
  always_comb begin
    advance  = 1'b0;
    capture  = 1'b0;
    count_en = 1'b0;
    if (!redirect_valid) begin
      advance  = (state == BOOT) || !stall;
      capture  = (state == RUN) && stall;
      count_en = resp_valid && !stall;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      count      <= '0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc;
      resp_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      if (advance) begin
        resp_pc    <= pc;
        resp_valid <= 1'b1;
        pc         <= pc + ADDRESS_WIDTH'(1);
        hold_valid <= 1'b0;
      end
      if (capture) begin
        hold_instr <= rom_data;
        hold_valid <= 1'b1;
      end
      if (count_en) count <= count + 32'd1;
    end
  end

  assign rom_addr    = pc;
  assign rom_wEn     = 1'b0;
  assign instr       = hold_valid ? hold_instr : rom_data;
  assign instr_pc    = resp_pc;
  assign instr_valid = resp_valid;
  assign fetch_count = count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM[n] = n + 0x100, one default instance and one starting near wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic [11:0] rom_addr, rom_addr2;
  logic        rom_wEn, rom_wEn2;
  logic [31:0] rom_data, rom_data2;
  logic [31:0] instr, instr2;
  logic [11:0] instr_pc, instr_pc2;
  logic        instr_valid, instr_valid2;
  logic [31:0] fetch_count, fetch_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data  <= 32'h100 + {20'd0, rom_addr};
    rom_data2 <= 32'h100 + {20'd0, rom_addr2};
  end

  instr_fetch #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32), .RESET_PC(12'd0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_wEn(rom_wEn),
    .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .fetch_count(fetch_count)
  );

  instr_fetch #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32), .RESET_PC(12'd4094)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(12'd0), .rom_addr(rom_addr2), .rom_wEn(rom_wEn2),
    .rom_data(rom_data2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .fetch_count(fetch_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [11:0] pc,
                         input logic [31:0] ins, input logic [31:0] cnt);
    chk({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, v});
    chk({tag, "_pc"}, {20'd0, instr_pc}, {20'd0, pc});
    if (v) chk({tag, "_instr"}, instr, ins);
    chk({tag, "_count"}, fetch_count, cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step; step;
    chk("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", {20'd0, instr_pc}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_wen", {31'd0, rom_wEn}, 32'd0);
    chk("rst_wrap_addr", {20'd0, rom_addr2}, 32'd4094);
    reset = 1'b0;

    // Straight-line fetch; wrap instance alongside.
    step; chk_out("e1", 1'b1, 12'd0, 32'h100, 32'd0);
    chk("wrap1_pc", {20'd0, instr_pc2}, 32'd4094);
    chk("wrap1_instr", instr2, 32'h100 + 32'd4094);
    step; chk_out("e2", 1'b1, 12'd1, 32'h101, 32'd1);
    chk("wrap2_pc", {20'd0, instr_pc2}, 32'd4095);
    step; chk_out("e3", 1'b1, 12'd2, 32'h102, 32'd2);
    chk("wrap3_pc", {20'd0, instr_pc2}, 32'd0);
    chk("wrap3_instr", instr2, 32'h100);
    step; chk_out("e4", 1'b1, 12'd3, 32'h103, 32'd3);
    chk("wrap4_pc", {20'd0, instr_pc2}, 32'd1);
    step; chk_out("e5", 1'b1, 12'd4, 32'h104, 32'd4);
    step; chk_out("e6", 1'b1, 12'd5, 32'h105, 32'd5);

    // Stall three cycles with pc 5 presented.
    stall = 1'b1;
    step; chk_out("st1", 1'b1, 12'd5, 32'h105, 32'd5);
    step; chk_out("st2", 1'b1, 12'd5, 32'h105, 32'd5);
    step; chk_out("st3", 1'b1, 12'd5, 32'h105, 32'd5);
    stall = 1'b0;
    step; chk_out("st_rel", 1'b1, 12'd6, 32'h106, 32'd6);

    // Redirect while running.
    redirect_valid = 1'b1; redirect_pc = 12'h200;
    step; chk("rd_bubble_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd_bubble_count", fetch_count, 32'd6);
    chk("rd_rom_addr", {20'd0, rom_addr}, 32'h200);
    redirect_valid = 1'b0;
    step; chk_out("rd_tgt", 1'b1, 12'h200, 32'h300, 32'd6);
    step; chk_out("rd_next", 1'b1, 12'h201, 32'h301, 32'd7);

    // Redirect plus stall while in STALL: held instruction dropped.
    stall = 1'b1;
    step; chk_out("rs_hold", 1'b1, 12'h201, 32'h301, 32'd7);
    redirect_valid = 1'b1; redirect_pc = 12'h010;
    step; chk("rs_bubble_valid", {31'd0, instr_valid}, 32'd0);
    chk("rs_bubble_count", fetch_count, 32'd7);
    redirect_valid = 1'b0;
    step; chk_out("rs_tgt", 1'b1, 12'h010, 32'h110, 32'd7);
    step; chk_out("rs_tgt_hold", 1'b1, 12'h010, 32'h110, 32'd7);

    // Asynchronous reset pulse between edges while stalled.
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_rom_addr", {20'd0, rom_addr}, 32'd0);
    chk("ar_count", fetch_count, 32'd0);
    chk("ar_pc", {20'd0, instr_pc}, 32'd0);
    #2 reset = 1'b0;
    stall = 1'b0;
    step; chk_out("ar_e1", 1'b1, 12'd0, 32'h100, 32'd0);
    step; chk_out("ar_e2", 1'b1, 12'd1, 32'h101, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
